// File: rtl/delay_sched_pkg.sv
// Shared definitions for the delay-line scheduler: default sizes, data width
// and the scheduler FSM state encoding.
package delay_sched_pkg;

    localparam int DATA_W      = 8;
    localparam int NUM_REQ_DEF = 4;
    localparam int DEPTH_DEF   = 2;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/delay_line_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the first asserted valid at or after
// ptr_i (wrapping modulo NUM_REQ) wins.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    grant_idx_o,
    output logic               any_grant_o
);

    int idx;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_grant_o = 1'b0;
        idx         = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // Explicit wrap so non-power-of-two NUM_REQ works.
            idx = int'(ptr_i) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!any_grant_o && valid_i[ID_W'(idx)]) begin
                any_grant_o             = 1'b1;
                grant_idx_o             = ID_W'(idx);
                grant_o[ID_W'(idx)]     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/delay_line_scheduler.sv
// Shares one free-running 8-bit delay line among NUM_REQ requesters and tracks
// which requester owns the bytes at the first and last delay-line stages.
module delay_line_scheduler
    import delay_sched_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]         shift_in,
    input  logic [DATA_W-1:0]         tap_a_in,
    input  logic [DATA_W-1:0]         tap_b_in,
    output logic                      a_valid,
    output logic [ID_W-1:0]           a_id,
    output logic [DATA_W-1:0]         a_data,
    output logic                      b_valid,
    output logic [ID_W-1:0]           b_id,
    output logic [DATA_W-1:0]         b_data,
    input  logic                      flush_req,
    output logic                      flush_done,
    output logic                      busy
);

    localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH + 1) : 1;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DEPTH-1:0]  vld_q;
    logic [ID_W-1:0]   id_q [DEPTH];

    logic [NUM_REQ-1:0] arb_gnt;
    logic [ID_W-1:0]    arb_idx;
    logic               arb_any;
    logic               grant_en;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .valid_i     (req_valid),
        .ptr_i       (ptr_q),
        .grant_o     (arb_gnt),
        .grant_idx_o (arb_idx),
        .any_grant_o (arb_any)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        grant_en = 1'b0;
        case (state_q)
            ST_RUN: begin
                // The RUN cycle that accepts the flush is itself the first
                // bubble, so FLUSH only covers the remaining DEPTH-1 stages.
                if (flush_req) begin
                    if (DEPTH == 1) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FLUSH;
                        cnt_d   = CNT_W'(DEPTH - 1);
                    end
                end else if (arb_any) begin
                    grant_en = 1'b1;
                    ptr_d    = (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + ID_W'(1);
                end
            end
            ST_FLUSH: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_d == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Grant outputs are forced low while reset is held so an asynchronous
    // reset silences the requesters without waiting for a clock edge.
    always_comb begin
        req_ready = (grant_en && !rst) ? arb_gnt : '0;
        shift_in  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                shift_in = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Valid/ID pipeline shifts every cycle in lockstep with the delay line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                id_q[k] <= '0;
            end
        end else begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                vld_q[k] <= vld_q[k-1];
                id_q[k]  <= id_q[k-1];
            end
            vld_q[0] <= grant_en;
            id_q[0]  <= grant_en ? arb_idx : '0;
        end
    end

    assign a_valid    = vld_q[0];
    assign a_id       = id_q[0];
    assign b_valid    = vld_q[DEPTH-1];
    assign b_id       = id_q[DEPTH-1];
    assign a_data     = tap_a_in;
    assign b_data     = tap_b_in;
    assign flush_done = (state_q == ST_DONE);
    assign busy       = (|vld_q) || (state_q != ST_RUN);

endmodule

// File: tb/tb_delay_line_scheduler.sv
// Bench for delay_line_scheduler: an external delay line, a timeline-based
// reference model checked every cycle, plus directed literal scenarios.
module tb_delay_line_scheduler;

    localparam int NR = 4;
    localparam int D  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // DUT with DEPTH=2
    logic [NR-1:0]   req_valid;
    logic [NR*8-1:0] req_data;
    logic [NR-1:0]   req_ready;
    logic [7:0]      shift_in, tap_a, tap_b, a_data, b_data;
    logic            a_valid, b_valid, flush_req, flush_done, busy;
    logic [1:0]      a_id, b_id;
    logic [7:0]      dl [D];

    // DUT with DEPTH=1
    logic [NR-1:0]   r1_valid;
    logic [NR*8-1:0] r1_data;
    logic [NR-1:0]   r1_ready;
    logic [7:0]      s1_in, t1_a, t1_b, a1_data, b1_data;
    logic            a1_valid, b1_valid, f1_req, f1_done, busy1;
    logic [1:0]      a1_id, b1_id;
    logic [7:0]      dl1;

    delay_line_scheduler #(.NUM_REQ(NR), .DEPTH(D)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .shift_in(shift_in), .tap_a_in(tap_a), .tap_b_in(tap_b),
        .a_valid(a_valid), .a_id(a_id), .a_data(a_data),
        .b_valid(b_valid), .b_id(b_id), .b_data(b_data),
        .flush_req(flush_req), .flush_done(flush_done), .busy(busy)
    );

    delay_line_scheduler #(.NUM_REQ(NR), .DEPTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(r1_valid), .req_data(r1_data),
        .req_ready(r1_ready), .shift_in(s1_in), .tap_a_in(t1_a), .tap_b_in(t1_b),
        .a_valid(a1_valid), .a_id(a1_id), .a_data(a1_data),
        .b_valid(b1_valid), .b_id(b1_id), .b_data(b1_data),
        .flush_req(f1_req), .flush_done(f1_done), .busy(busy1)
    );

    // External delay lines: no reset, no enable.
    always @(posedge clk) begin
        dl[0] <= shift_in;
        for (int k = 1; k < D; k++) dl[k] <= dl[k-1];
        dl1 <= s1_in;
    end
    assign tap_a = dl[0];
    assign tap_b = dl[D-1];
    assign t1_a  = dl1;
    assign t1_b  = dl1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a per-cycle grant log; stage k at cycle c holds the
    // grant made at cycle c-1-k (if after the last reset).
    bit m_lv   [8192];
    int m_lid  [8192];
    int m_ldat [8192];
    int m_cyc  = 0;
    int m_base = 0;
    int m_fs   = -100;
    int m_ptr  = 0;
    int m_eg, m_j, m_exp_ready, m_exp_data;
    bit m_av, m_bv, m_inflush;

    function automatic bit st_v(input int c, input int k);
        int idx = c - 1 - k;
        return (idx >= 0) && (idx >= m_base) && m_lv[idx];
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            check("rst_req_ready", int'(req_ready), 0);
            check("rst_a_valid", int'(a_valid), 0);
            check("rst_b_valid", int'(b_valid), 0);
            check("rst_busy", int'(busy), 0);
            check("rst_flush_done", int'(flush_done), 0);
            m_base = m_cyc + 1;
            m_fs   = -100;
            m_ptr  = 0;
            m_lv[m_cyc] = 1'b0;
        end else begin
            m_av = st_v(m_cyc, 0);
            m_bv = st_v(m_cyc, D - 1);
            check("a_valid", int'(a_valid), int'(m_av));
            check("b_valid", int'(b_valid), int'(m_bv));
            if (m_av) begin
                check("a_id", int'(a_id), m_lid[m_cyc-1]);
                check("a_data", int'(a_data), m_ldat[m_cyc-1]);
            end
            if (m_bv) begin
                check("b_id", int'(b_id), m_lid[m_cyc-D]);
                check("b_data", int'(b_data), m_ldat[m_cyc-D]);
            end
            m_inflush = (m_cyc > m_fs) && (m_cyc <= m_fs + D);
            check("busy", int'(busy), int'(m_av || m_bv || st_v(m_cyc, 1) || m_inflush));
            check("flush_done", int'(flush_done), int'(m_cyc == m_fs + D));

            m_eg = -1;
            if (!((m_cyc >= m_fs) && (m_cyc <= m_fs + D))) begin
                if (flush_req) begin
                    m_fs = m_cyc;
                end else begin
                    for (int i = 0; i < NR; i++) begin
                        m_j = (m_ptr + i) % NR;
                        if (m_eg < 0 && req_valid[m_j]) m_eg = m_j;
                    end
                end
            end
            m_exp_ready = (m_eg >= 0) ? (1 << m_eg) : 0;
            m_exp_data  = (m_eg >= 0) ? int'(req_data[m_eg*8 +: 8]) : 0;
            check("req_ready", int'(req_ready), m_exp_ready);
            check("shift_in", int'(shift_in), m_exp_data);
            m_lv[m_cyc]   = (m_eg >= 0);
            m_lid[m_cyc]  = m_eg;
            m_ldat[m_cyc] = m_exp_data;
            if (m_eg >= 0) m_ptr = (m_eg + 1) % NR;
        end
        m_cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic peek();
        @(negedge clk);
        #1;
    endtask

    initial begin
        req_valid = '0; req_data = '0; flush_req = 1'b0;
        r1_valid  = '0; r1_data  = '0; f1_req    = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Single requester 2 with 0x3C
        req_valid = 4'b0100; req_data[23:16] = 8'h3C;
        peek(); check("t1_ready", int'(req_ready), 4);
        check("t1_shift_in", int'(shift_in), 8'h3C);
        step(); req_valid = '0;
        peek(); check("t1_a_valid", int'(a_valid), 1); check("t1_a_id", int'(a_id), 2);
        step();
        peek(); check("t1_b_valid", int'(b_valid), 1); check("t1_b_id", int'(b_id), 2);
        check("t1_b_data", int'(b_data), 8'h3C);
        step();

        // Reset pulse so the pointer restarts at 0
        rst = 1'b1; step(); rst = 1'b0;

        // All four valid, data 0x10+i
        req_valid = 4'hF; req_data = 32'h13121110;
        for (int k = 0; k < 8; k++) begin
            peek();
            check("t2_ready", int'(req_ready), 1 << (k % 4));
            if (k >= 2) begin
                check("t2_b_id", int'(b_id), (k - 2) % 4);
                check("t2_b_data", int'(b_data), 8'h10 + (k - 2) % 4);
            end
            step();
        end

        // Move pointer to 2, then requesters 1 and 3
        req_valid = 4'b0010;
        peek(); check("t3_pre_ready", int'(req_ready), 2); step();
        req_valid = 4'b1010;
        peek(); check("t3_ready0", int'(req_ready), 8); step();
        peek(); check("t3_ready1", int'(req_ready), 2); step();
        peek(); check("t3_ready2", int'(req_ready), 8); step();

        // Flush pulse while requester 0 is valid
        req_valid = 4'b0001; flush_req = 1'b1;
        peek(); check("t4_ready_c0", int'(req_ready), 0); step();
        flush_req = 1'b0;
        peek(); check("t4_ready_c1", int'(req_ready), 0);
        check("t4_done_c1", int'(flush_done), 0); step();
        peek(); check("t4_done_c2", int'(flush_done), 1);
        check("t4_a_valid_c2", int'(a_valid), 0); check("t4_b_valid_c2", int'(b_valid), 0);
        check("t4_ready_c2", int'(req_ready), 0); step();
        peek(); check("t4_ready_c3", int'(req_ready), 1); check("t4_busy_c3", int'(busy), 0);
        step();
        step();

        // Asynchronous reset between edges with both stages valid
        req_valid = 4'b0101;
        #1 check("t5_b_valid_pre", int'(b_valid), 1);
        rst = 1'b1;
        #1;
        check("t5_a_valid", int'(a_valid), 0); check("t5_b_valid", int'(b_valid), 0);
        check("t5_ready", int'(req_ready), 0); check("t5_busy", int'(busy), 0);
        step();
        #2 rst = 1'b0;
        peek(); check("t5_first_grant", int'(req_ready), 1);
        step();
        req_valid = '0;

        // DEPTH=1 instance
        r1_valid = 4'b0010; r1_data[15:8] = 8'hA5;
        peek(); check("t6_ready", int'(r1_ready), 2); step();
        r1_valid = '0;
        peek();
        check("t6_a_valid", int'(a1_valid), 1); check("t6_b_valid", int'(b1_valid), 1);
        check("t6_a_id", int'(a1_id), 1); check("t6_b_id", int'(b1_id), 1);
        check("t6_a_data", int'(a1_data), 8'hA5); check("t6_b_data", int'(b1_data), 8'hA5);
        step();
        f1_req = 1'b1; step(); f1_req = 1'b0;
        peek(); check("t6_flush_done", int'(f1_done), 1);
        check("t6_done_b_valid", int'(b1_valid), 0);
        step();

        // Randomized traffic with flushes and one mid-run asynchronous reset
        for (int n = 0; n < 3000; n++) begin
            req_valid = 4'($urandom_range(0, 15));
            req_data  = $urandom;
            flush_req = ($urandom_range(0, 19) == 0);
            if (n == 1500) begin
                #2 rst = 1'b1;
                step();
                #2 rst = 1'b0;
            end else begin
                step();
            end
        end
        req_valid = '0; flush_req = 1'b0;
        repeat (6) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
